// File: rtl/bram_rect_writer.sv
// Rectangle-fill write engine for the square RGB frame buffer.
// Each accepted command is clipped to the buffer edges and then written out pixel by pixel in raster order.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | cmd_ready high; latches and clips the next command
// FILL  | one pixel per cycle in which wr_allow is high; counters hold otherwise
// DONE  | single-cycle completion pulse, then back to IDLE
module bram_rect_writer #(
    parameter int ADDR_BITS = 7,
    parameter int DATA_W    = 12
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [ADDR_BITS-1:0] cmd_x,
    input  logic [ADDR_BITS-1:0] cmd_y,
    input  logic [ADDR_BITS:0]   cmd_w,
    input  logic [ADDR_BITS:0]   cmd_h,
    input  logic [DATA_W-1:0]    cmd_color,
    input  logic                 wr_allow,
    output logic                 we,
    output logic [ADDR_BITS-1:0] wr_row,
    output logic [ADDR_BITS-1:0] wr_col,
    output logic [DATA_W-1:0]    wr_data,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [ADDR_BITS:0] SPAN = {1'b1, {ADDR_BITS{1'b0}}};
    localparam logic [ADDR_BITS:0] ONE  = {{ADDR_BITS{1'b0}}, 1'b1};

    state_t               state, state_nxt;
    logic [ADDR_BITS-1:0] x_q, y_q;
    logic [DATA_W-1:0]    color_q;
    logic [ADDR_BITS:0]   ew_q, eh_q;
    logic [ADDR_BITS-1:0] col_cnt, row_cnt;

    logic [ADDR_BITS:0]   room_x, room_y;
    logic [ADDR_BITS:0]   clip_w, clip_h;
    logic                 accept;
    logic                 last_col, last_row;

    // Room to the edge is 1..SPAN, computed one bit wider so it never wraps.
    assign room_x = SPAN - {1'b0, cmd_x};
    assign room_y = SPAN - {1'b0, cmd_y};
    assign clip_w = (cmd_w < room_x) ? cmd_w : room_x;
    assign clip_h = (cmd_h < room_y) ? cmd_h : room_y;

    assign last_col = ({1'b0, col_cnt} == (ew_q - ONE));
    assign last_row = ({1'b0, row_cnt} == (eh_q - ONE));

    assign wr_row  = y_q + row_cnt;
    assign wr_col  = x_q + col_cnt;
    assign wr_data = color_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        we        = 1'b0;
        accept    = 1'b0;
        case (state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    accept    = 1'b1;
                    state_nxt = ((clip_w == '0) || (clip_h == '0)) ? S_DONE : S_FILL;
                end
            end
            S_FILL: begin
                busy = 1'b1;
                we   = wr_allow;
                if (wr_allow && last_col && last_row) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_q     <= '0;
            y_q     <= '0;
            color_q <= '0;
            ew_q    <= '0;
            eh_q    <= '0;
            col_cnt <= '0;
            row_cnt <= '0;
        end else if (accept) begin
            x_q     <= cmd_x;
            y_q     <= cmd_y;
            color_q <= cmd_color;
            ew_q    <= clip_w;
            eh_q    <= clip_h;
            col_cnt <= '0;
            row_cnt <= '0;
        end else if (we) begin
            // Row counter parks on the final row so addresses stay in range after the last pixel.
            if (last_col) begin
                col_cnt <= '0;
                if (!last_row) begin
                    row_cnt <= row_cnt + 1'b1;
                end
            end else begin
                col_cnt <= col_cnt + 1'b1;
            end
        end
    end

endmodule

// File: doc/bram_rect_writer.md
Name: bram_rect_writer

Overview:
- Write-side engine for the 128x128 RGB frame buffer that the VGA path reads.
- Accepts rectangle-fill commands (origin, size, 12-bit colour) over a valid/ready handshake.
- Emits one BRAM write per permitted cycle, in raster order, clipped to the buffer edges.
- Used for screen clears and solid-block drawing; the display side stays read-only.

Parameters:
ADDR_BITS, 7, row/col address width; buffer is 2^ADDR_BITS square (128)
DATA_W, 12, pixel width, packed {B,G,R} 4 bits each

Ports:
clk  input  1  pixel clock (25 MHz domain)
reset_n  input  1  asynchronous, active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  engine can accept a command
cmd_x  input  ADDR_BITS  rectangle left column
cmd_y  input  ADDR_BITS  rectangle top row
cmd_w  input  ADDR_BITS+1  width in pixels, 0..255
cmd_h  input  ADDR_BITS+1  height in pixels, 0..255
cmd_color  input  DATA_W  fill colour
wr_allow  input  1  write slot granted this cycle (tie high or drive from blanking)
we  output  1  BRAM write enable
wr_row  output  ADDR_BITS  write row address
wr_col  output  ADDR_BITS  write column address
wr_data  output  DATA_W  write data
busy  output  1  command in progress
done  output  1  one-cycle completion pulse

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - state=IDLE; we=0, busy=0, done=0, cmd_ready=1.
  - wr_row, wr_col and wr_data all 0; latched command cleared.
- States: IDLE, FILL, DONE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready, latch x, y and colour, plus clipped sizes:
    - ew = min(cmd_w, 2^ADDR_BITS - cmd_x)
    - eh = min(cmd_h, 2^ADDR_BITS - cmd_y)
    - The subtraction is done at ADDR_BITS+1 bits, so it yields 1..128 with no wrap.
  - If ew==0 or eh==0, go to DONE. Otherwise go to FILL with col counter=0 and row counter=0.
- FILL:
  - busy=1, cmd_ready=0.
  - Write outputs: we = wr_allow (combinational from state), wr_row = y+row_cnt, wr_col = x+col_cnt, wr_data = colour.
  - Counters advance only on cycles with we=1; with wr_allow=0 everything holds and no pixel is skipped.
  - Order: col_cnt increments. When col_cnt==ew-1 it wraps to 0 and row_cnt increments.
  - On the write where col_cnt==ew-1 and row_cnt==eh-1, go to DONE.
- DONE:
  - Lasts one cycle: done=1, busy=1, we=0, cmd_ready=0.
  - Then return to IDLE.
- Latency:
  - Accept on cycle N; first write at N+1 (if wr_allow).
  - Total writes = ew*eh. done fires the cycle after the last write.
  - With ew or eh zero, done fires at N+1 with no writes.
- cmd_valid while busy: ignored, with no latching or side effects. The command is accepted when the engine returns to IDLE if cmd_valid is still held.
- Address arithmetic: clipping guarantees x+col_cnt and y+row_cnt never exceed 2^ADDR_BITS-1. No wrap is ever produced.
- Reset mid-FILL: immediate abort, we drops asynchronously, no done pulse, remaining pixels unwritten.
- cmd_x/cmd_y/cmd_color changing after acceptance: no effect; only latched values are used.

Test Plan:
- Clear: cmd (0,0,128,128,12'h000), wr_allow=1.
  - Exactly 16384 writes on consecutive cycles, raster order.
  - Last write at row 127, col 127; done at accept+16385.
- Clip: cmd (120,120,16,16,12'hF00).
  - 64 writes covering rows and cols 120..127.
  - First write (120,120), last (127,127), wr_data=12'hF00.
- Zero size: cmd (10,10,0,5,12'h0F0).
  - No writes; done one cycle after accept; cmd_ready high the following cycle.
- Throttle: cmd (0,0,4,2,12'h00F) with wr_allow toggling 1,0,1,0.
  - 8 writes over 15 cycles; address sequence identical to the unthrottled run.
  - Counters hold while wr_allow=0.
- Back-to-back: cmd_valid held high with two commands queued by the bench.
  - Second command accepted only in the IDLE cycle after done.
  - cmd_ready=0 throughout FILL and DONE.
- Reset abort: assert reset_n=0 after 5 writes of a 128x128 clear.
  - we=0 asynchronously; busy=0, done never pulses, cmd_ready=1.
  - After release, a fresh command starts at its own origin.
